// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with pending-write scoreboard
//
// Purpose: 2**ADDR_W x DATA_W register file for the pipelined MIPS datapath.
//   Register 0 is hardwired to zero. Each entry has a busy bit: it is set by
//   decode on allocation and cleared by the writeback write. Every read port
//   returns registered data, the registered busy bit and a one-cycle valid
//   pulse.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-edge writeback
//   to a read of the same nonzero index. Without it, such a read returns the
//   pre-write entry and busy bit.
// Ports:
//   Clk        clock, all state updates on the rising edge
//   Rst        synchronous active-high reset
//   RegWrite   write enable; WriteR index, WriteD signed data
//   AllocEn    mark AllocR busy (write in flight)
//   ReadEn     per-port read enable
//   ReadR      packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   ReadD      packed registered read data, port i at [i*DATA_W +: DATA_W]
//   ReadValid  per-port one-cycle pulse after each enabled read
//   ReadBusy   per-port registered busy bit of the register read
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteR,
  input  logic signed [DATA_W-1:0] WriteD,
  input  logic                     AllocEn,
  input  logic [ADDR_W-1:0]        AllocR,
  input  logic [NREAD-1:0]         ReadEn,
  input  logic [NREAD*ADDR_W-1:0]  ReadR,
  output logic [NREAD*DATA_W-1:0]  ReadD,
  output logic [NREAD-1:0]         ReadValid,
  output logic [NREAD-1:0]         ReadBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [NREAD*DATA_W-1:0] rd_q, rd_d;
  logic [NREAD-1:0]        rv_q, rv_d;
  logic [NREAD-1:0]        rb_q, rb_d;
  logic [ADDR_W-1:0]       idx;

  // Storage and scoreboard next state. Index 0 is never written or
  // allocated, so it stays at its reset value of zero forever.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (RegWrite && (WriteR != '0)) begin
      mem_d[WriteR]  = WriteD;
      busy_d[WriteR] = 1'b0;
    end
    // Applied after the write so a same-edge allocation (new producer) wins.
    if (AllocEn && (AllocR != '0)) begin
      busy_d[AllocR] = 1'b1;
    end
  end

  // Read ports: disabled ports hold data/busy and drop valid.
  always_comb begin
    rd_d = rd_q;
    rb_d = rb_q;
    rv_d = ReadEn;
    idx  = '0;
    for (int i = 0; i < NREAD; i++) begin
      idx = ReadR[i*ADDR_W +: ADDR_W];
      if (ReadEn[i]) begin
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (WriteR == idx) && (idx != '0)) begin
          rd_d[i*DATA_W +: DATA_W] = WriteD;
          rb_d[i]                  = AllocEn && (AllocR == idx);
        end else begin
          rd_d[i*DATA_W +: DATA_W] = mem_q[idx];
          rb_d[i]                  = busy_q[idx];
        end
`else
        rd_d[i*DATA_W +: DATA_W] = mem_q[idx];
        rb_d[i]                  = busy_q[idx];
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q <= '0;
      rd_q   <= '0;
      rv_q   <= '0;
      rb_q   <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      rv_q   <= rv_d;
      rb_q   <= rb_d;
    end
  end

  assign ReadD     = rd_q;
  assign ReadValid = rv_q;
  assign ReadBusy  = rb_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table-driven and model-checked bench for regfile_mp
module tb_regfile_mp;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RegWrite;
  logic [4:0]  WriteR;
  logic [31:0] WriteD;
  logic        AllocEn;
  logic [4:0]  AllocR;
  logic [1:0]  ReadEn;
  logic [9:0]  ReadR;
  logic [63:0] ReadD;
  logic [1:0]  ReadValid;
  logic [1:0]  ReadBusy;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (
    .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .AllocEn(AllocEn), .AllocR(AllocR), .ReadEn(ReadEn), .ReadR(ReadR),
    .ReadD(ReadD), .ReadValid(ReadValid), .ReadBusy(ReadBusy)
  );

  always #5 Clk = ~Clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst, we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  ar;
    logic [1:0]  re;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic        b0, b1;
    logic [1:0]  v;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input logic rst, we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic ae,
                              input logic [4:0] ar, input logic [1:0] re,
                              input logic [4:0] r0, r1,
                              input logic [31:0] d0, d1,
                              input logic b0, b1, input logic [1:0] v);
    vec_t x;
    x.rst = rst; x.we = we; x.wr = wr; x.wd = wd; x.ae = ae; x.ar = ar;
    x.re = re; x.r0 = r0; x.r1 = r1; x.d0 = d0; x.d1 = d1;
    x.b0 = b0; x.b1 = b1; x.v = v;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one record, push its expectation, compare after the edge.
  task automatic apply(input vec_t x, input string tag);
    vec_t e;
    @(negedge Clk);
    Rst = x.rst; RegWrite = x.we; WriteR = x.wr; WriteD = x.wd;
    AllocEn = x.ae; AllocR = x.ar; ReadEn = x.re; ReadR = {x.r1, x.r0};
    exp_q.push_back(x);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " d0"}, ReadD[31:0], e.d0);
    chk({tag, " d1"}, ReadD[63:32], e.d1);
    chk({tag, " busy"}, {30'd0, ReadBusy}, {30'd0, e.b1, e.b0});
    chk({tag, " valid"}, {30'd0, ReadValid}, {30'd0, e.v});
  endtask

  // Behavioural model for the random phase.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic [31:0] m_d [2];
  logic        m_b [2];

  function automatic vec_t model_step(input vec_t x);
    vec_t    y;
    logic [4:0] ri;
    y = x;
    for (int p = 0; p < 2; p++) begin
      ri = (p == 0) ? x.r0 : x.r1;
      if (x.rst) begin
        m_d[p] = 32'd0; m_b[p] = 1'b0;
      end else if (x.re[p]) begin
        if (BYP && x.we && x.wr == ri && ri != 5'd0) begin
          m_d[p] = x.wd; m_b[p] = x.ae && (x.ar == ri);
        end else begin
          m_d[p] = m_mem[ri]; m_b[p] = m_busy[ri];
        end
      end
    end
    if (x.rst) begin
      for (int k = 0; k < 32; k++) m_mem[k] = 32'd0;
      m_busy = 32'd0;
    end else begin
      if (x.we && x.wr != 5'd0) begin m_mem[x.wr] = x.wd; m_busy[x.wr] = 1'b0; end
      if (x.ae && x.ar != 5'd0) m_busy[x.ar] = 1'b1;
    end
    y.d0 = m_d[0]; y.d1 = m_d[1]; y.b0 = m_b[0]; y.b1 = m_b[1];
    y.v = x.rst ? 2'b00 : x.re;
    return y;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    vec_t x;
    Rst = 1'b1; RegWrite = 1'b0; WriteR = '0; WriteD = '0;
    AllocEn = 1'b0; AllocR = '0; ReadEn = '0; ReadR = '0;

    // Reset for two cycles with reads requested: reset overrides them.
    vecs.push_back(mk(1,0,0,0, 0,0, 2'b11, 5,7, 0,0, 0,0, 2'b00));
    vecs.push_back(mk(1,0,0,0, 0,0, 2'b11, 5,7, 0,0, 0,0, 2'b00));
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 5'(i),5'(31-i), 0,0, 0,0, 2'b11));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b00, 0,0, 0,0, 0,0, 2'b00));
    // Write then read on both ports.
    vecs.push_back(mk(0,1,5,32'hDEADBEEF, 0,0, 2'b00, 0,0, 0,0, 0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 5,5, 32'hDEADBEEF,32'hDEADBEEF, 0,0, 2'b11));
    // Zero register: write and allocate are discarded.
    vecs.push_back(mk(0,1,0,32'h12345678, 1,0, 2'b00, 0,0, 32'hDEADBEEF,32'hDEADBEEF, 0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 0,0, 0,0, 0,0, 2'b11));
    // Scoreboard: allocate r7, read busy, write clears it.
    vecs.push_back(mk(0,0,0,0, 1,7, 2'b00, 0,0, 0,0, 0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 7,7, 0,0, 1,1, 2'b11));
    vecs.push_back(mk(0,1,7,32'h55, 0,0, 2'b00, 0,0, 0,0, 1,1, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 7,7, 32'h55,32'h55, 0,0, 2'b11));
    // Enable low: data holds, valid drops.
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b00, 1,2, 32'h55,32'h55, 0,0, 2'b00));
    // Same-edge allocate and write: busy ends at 1.
    vecs.push_back(mk(0,1,9,32'hAA, 1,9, 2'b00, 0,0, 32'h55,32'h55, 0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 9,7, 32'hAA,32'h55, 1,0, 2'b11));
    // Same-cycle read-after-write on r3, port 1 idle.
    vecs.push_back(mk(0,1,3,32'h1, 0,0, 2'b00, 0,0, 32'hAA,32'h55, 1,0, 2'b00));
    vecs.push_back(mk(0,1,3,32'h2, 0,0, 2'b01, 3,3, BYP ? 32'h2 : 32'h1,32'h55, 0,0, 2'b01));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b01, 3,3, 32'h2,32'h55, 0,0, 2'b01));
    // Same-cycle write + allocate + read on r4.
    vecs.push_back(mk(0,1,4,32'h7, 1,4, 2'b11, 4,4, BYP ? 32'h7 : 32'h0, BYP ? 32'h7 : 32'h0,
                      BYP,BYP, 2'b11));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 4,4, 32'h7,32'h7, 1,1, 2'b11));
    // Reset mid-run with r7 busy and reads enabled.
    vecs.push_back(mk(0,0,0,0, 1,7, 2'b00, 0,0, 32'h7,32'h7, 1,1, 2'b00));
    vecs.push_back(mk(1,1,10,32'h99, 1,9, 2'b11, 7,7, 0,0, 0,0, 2'b00));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 7,10, 0,0, 0,0, 2'b11));
    vecs.push_back(mk(0,0,0,0, 0,0, 2'b11, 9,4, 0,0, 0,0, 2'b11));

    foreach (vecs[n]) apply(vecs[n], $sformatf("row%0d", n));

    // Random phase against the model; small index range forces collisions.
    x = mk(1,0,0,0, 0,0, 2'b00, 0,0, 0,0, 0,0, 2'b00);
    apply(model_step(x), "rnd reset");
    for (int n = 0; n < 300; n++) begin
      x.rst = ($urandom_range(0, 49) == 0);
      x.we  = $urandom_range(0, 1);
      x.wr  = 5'($urandom_range(0, 7));
      x.wd  = $urandom;
      x.ae  = ($urandom_range(0, 2) == 0);
      x.ar  = 5'($urandom_range(0, 7));
      x.re  = 2'($urandom_range(0, 3));
      x.r0  = 5'($urandom_range(0, 7));
      x.r1  = 5'($urandom_range(0, 7));
      apply(model_step(x), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the pipelined MIPS datapath. It replaces the fixed 32x32, two-read-port register file and adds:
- configurable width, depth and read-port count;
- per-port read enables with registered, valid-flagged outputs;
- a hardwired zero register;
- a per-register pending-write scoreboard that the decode stage uses for hazard stalls.

It sits between decode (reads, allocation) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32: register width in bits; data is signed.
- ADDR_W, 5: register index width; depth is 2**ADDR_W.
- NREAD, 2: number of independent read ports.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- RegWrite  input  1  write enable.
- WriteR  input  ADDR_W  write index.
- WriteD  input  DATA_W  write data (signed).
- AllocEn  input  1  mark a register as having a write in flight.
- AllocR  input  ADDR_W  index to mark busy.
- ReadEn  input  NREAD  per-port read enable.
- ReadR  input  NREAD*ADDR_W  read indices; port i uses bits [i*ADDR_W +: ADDR_W].
- ReadD  output  NREAD*DATA_W  registered read data; port i uses bits [i*DATA_W +: DATA_W].
- ReadValid  output  NREAD  high for one cycle after each enabled read.
- ReadBusy  output  NREAD  registered scoreboard state of the register read.

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, plus a busy bit per entry.
- Write: at a rising edge with RegWrite=1 and WriteR!=0, entry[WriteR] <= WriteD and busy[WriteR] <= 0.
- Register 0:
  - writes to it are discarded;
  - it always reads as 0;
  - its busy bit is always 0, and AllocEn with AllocR=0 is ignored.
- Allocate: at an edge with AllocEn=1 and AllocR!=0, busy[AllocR] <= 1.
- Same-edge allocate and write to the same index: the data write happens, and busy ends at 1 (the new producer wins).
- Read port i at an edge with ReadEn[i]=1:
  - ReadD[i] <= entry[ReadR[i]];
  - ReadBusy[i] <= busy[ReadR[i]];
  - ReadValid[i] <= 1.
- Read port i with ReadEn[i]=0: ReadValid[i] <= 0; ReadD[i] and ReadBusy[i] hold their values.
- Ports are independent. Any number of ports may read the same index in the same cycle; all return identical results.
- Reset (Rst=1 at an edge):
  - all entries cleared to 0 and all busy bits cleared;
  - ReadD all 0, ReadValid all 0, ReadBusy all 0;
  - reset overrides any simultaneous write, allocate or read.
- Reset asserted in the middle of a run: all pending scoreboard state is lost. The pipeline is flushed alongside, so no write in flight is preserved.

## Timing
- Read latency is 1 cycle: ReadR/ReadEn sampled at edge N produce ReadD/ReadBusy/ReadValid valid after edge N, usable throughout cycle N+1.
- Write latency: an entry holds the new value after the write edge.
- Same-cycle read-after-write (ReadR[i]==WriteR with RegWrite=1): the result depends on the configuration; see below.
- Each ReadValid bit is a single-cycle pulse per enabled read. Back-to-back enables give a continuously high ReadValid.
- No combinational path from inputs to outputs; every output is a flop.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined, for a read in the same cycle as a write to the same nonzero index:
  - ReadD returns WriteD;
  - ReadBusy returns 0, or 1 if a same-edge AllocEn targets that same index;
  - this makes writeback-to-decode forwarding internal.
- Not defined: the same read returns the pre-write entry and pre-write busy bit. The pipeline must then stall one cycle or forward externally.
- Register 0 behaviour is identical in both builds.

## Test plan
- Reset then read: assert Rst for 2 cycles, then read all 32 indices on both ports -> every ReadD=0, ReadBusy=0; ReadValid=1 exactly one cycle after each enable.
- Write/read: write 0xDEADBEEF to r5, next cycle read r5 on port 0 and r5 on port 1 -> both ports return 0xDEADBEEF (signed -559038737), ReadBusy=0.
- Zero register: write 0x12345678 to r0 and AllocEn with AllocR=0, then read r0 -> ReadD=0, ReadBusy=0.
- Scoreboard:
  - allocate r7, then read r7 -> ReadBusy=1;
  - write 0x55 to r7, then read r7 -> ReadD=0x55, ReadBusy=0;
  - allocate r9 and write r9 (value 0xAA) on the same edge, then read r9 -> ReadD=0xAA, ReadBusy=1.
- Same-cycle read-after-write: r3=0x1, then write 0x2 to r3 while reading r3 in the same cycle.
  - With REGFILE_BYPASS_EN -> ReadD=0x2.
  - Without it -> ReadD=0x1; the following read returns 0x2.
- Enable/hold and reset mid-run:
  - ReadEn=0 after a read of 0x55 -> ReadD holds 0x55, ReadValid=0;
  - assert Rst while r7 is busy and reads are enabled -> next cycle all outputs 0, and a subsequent read of r7 gives ReadD=0, ReadBusy=0.
